// File: rtl/riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_ctrl
// Description : Control FSM for a multi-cycle RV32I datapath (lw, sw, R/I ALU,
//               beq/bne, jal). Drives mux selects, ALU op and write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mc_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_we,
    output logic        adr_src,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  res_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [3:0]  alu_ctrl,
    output logic [3:0]  state,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLT  = 4'd5;
    localparam logic [3:0] c_ALU_SLL  = 4'd6;
    localparam logic [3:0] c_ALU_SRL  = 4'd7;
    localparam logic [3:0] c_ALU_SRA  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;

    localparam logic [1:0] c_IMM_I = 2'd0;
    localparam logic [1:0] c_IMM_S = 2'd1;
    localparam logic [1:0] c_IMM_B = 2'd2;
    localparam logic [1:0] c_IMM_J = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_f7b5;
    logic        w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_f7b5   = instr[30];
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};
    assign state    = r_state;

    // funct7[5] selects SUB only for register-register ops; SRA/SRL always honours it
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (allow_sub && f7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  op = c_ALU_SLL;
            3'b010:  op = c_ALU_SLT;
            3'b011:  op = c_ALU_SLTU;
            3'b100:  op = c_ALU_XOR;
            3'b101:  op = f7b5 ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  op = c_ALU_OR;
            default: op = c_ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        pc_we     = 1'b0;
        adr_src   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        res_src   = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        imm_src   = 2'd0;
        alu_ctrl  = c_ALU_ADD;
        illegal   = 1'b0;

        case (r_state)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = 2'd2;
                res_src   = 2'd2;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target is precomputed here into ALU-out
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                case (w_opcode)
                    c_OP_LOAD:   begin imm_src = c_IMM_I; w_next = S_MEMADR; end
                    c_OP_STORE:  begin imm_src = c_IMM_S; w_next = S_MEMADR; end
                    c_OP_RTYPE:  w_next = S_EXECR;
                    c_OP_ITYPE:  begin imm_src = c_IMM_I; w_next = S_EXECI;  end
                    c_OP_BRANCH: begin imm_src = c_IMM_B; w_next = S_BRANCH; end
                    c_OP_JAL:    begin imm_src = c_IMM_J; w_next = S_JAL;    end
                    default: begin
                        illegal = 1'b1;
                        w_next  = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                if (w_opcode == c_OP_STORE) begin
                    imm_src = c_IMM_S;
                    w_next  = S_MEMWRITE;
                end else begin
                    imm_src = c_IMM_I;
                    w_next  = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                res_src = 2'd1;
                reg_we  = 1'b1;
                w_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_we  = 1'b1;
                w_next  = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'd2;
                alu_ctrl  = alu_decode(w_funct3, w_f7b5, 1'b1);
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = c_IMM_I;
                alu_ctrl  = alu_decode(w_funct3, w_f7b5, 1'b0);
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_ctrl  = c_ALU_SUB;
                case (w_funct3)
                    3'b000:  pc_we = zero;
                    3'b001:  pc_we = ~zero;
                    default: pc_we = 1'b0;
                endcase
                w_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALU-out while ALU forms the link value
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_we     = 1'b1;
                w_next    = S_ALUWB;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (rst) begin
            pc_we   = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_mc_ctrl
// Description : Scoreboard bench for riscv_mc_ctrl in NOP and HALT modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic [31:0] instr0 = 32'h0;
    logic [31:0] instr1 = 32'h0;
    logic        zero = 1'b0;

    logic        pc_we0, adr_src0, mem_we0, ir_we0, reg_we0, illegal0;
    logic [1:0]  res_src0, alu_src_a0, alu_src_b0, imm_src0;
    logic [3:0]  alu_ctrl0, state0;
    logic        pc_we1, adr_src1, mem_we1, ir_we1, reg_we1, illegal1;
    logic [1:0]  res_src1, alu_src_a1, alu_src_b1, imm_src1;
    logic [3:0]  alu_ctrl1, state1;

    always #5 clk = ~clk;

    riscv_mc_ctrl #(.ILLEGAL_HALT(1'b0)) u_dut_nop (
        .clk(clk), .rst(rst0), .instr(instr0), .zero(zero),
        .pc_we(pc_we0), .adr_src(adr_src0), .mem_we(mem_we0), .ir_we(ir_we0),
        .reg_we(reg_we0), .res_src(res_src0), .alu_src_a(alu_src_a0),
        .alu_src_b(alu_src_b0), .imm_src(imm_src0), .alu_ctrl(alu_ctrl0),
        .state(state0), .illegal(illegal0)
    );

    riscv_mc_ctrl #(.ILLEGAL_HALT(1'b1)) u_dut_halt (
        .clk(clk), .rst(rst1), .instr(instr1), .zero(zero),
        .pc_we(pc_we1), .adr_src(adr_src1), .mem_we(mem_we1), .ir_we(ir_we1),
        .reg_we(reg_we1), .res_src(res_src1), .alu_src_a(alu_src_a1),
        .alu_src_b(alu_src_b1), .imm_src(imm_src1), .alu_ctrl(alu_ctrl1),
        .state(state1), .illegal(illegal1)
    );

    logic [21:0] w_obs0, w_obs1;
    assign w_obs0 = {state0, pc_we0, adr_src0, mem_we0, ir_we0, reg_we0, res_src0,
                     alu_src_a0, alu_src_b0, imm_src0, alu_ctrl0, illegal0};
    assign w_obs1 = {state1, pc_we1, adr_src1, mem_we1, ir_we1, reg_we1, res_src1,
                     alu_src_a1, alu_src_b1, imm_src1, alu_ctrl1, illegal1};

    localparam logic [21:0] c_FULL   = 22'h3FFFFF;
    localparam logic [21:0] c_ENABLE = 22'h02E001;
    localparam logic [21:0] c_ENST   = 22'h3EE001;

    typedef struct {
        logic        rst;
        logic        zero;
        logic [21:0] exp;
        logic [21:0] mask;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic logic [21:0] mk(input logic [3:0] st, input logic pc,
                                       input logic adr, input logic mem,
                                       input logic ir, input logic rg,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] imm,
                                       input logic [3:0] alu, input logic ill);
        return {st, pc, adr, mem, ir, rg, res, a, b, imm, alu, ill};
    endfunction

    function automatic logic [21:0] v_fetch();
        return mk(4'd0, 1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 2'd0, 4'd0, 0);
    endfunction
    function automatic logic [21:0] v_decode(input logic [1:0] imm, input logic ill);
        return mk(4'd1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 4'd0, ill);
    endfunction
    function automatic logic [21:0] v_aluwb();
        return mk(4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0);
    endfunction

    task automatic push(input logic r, input logic z, input logic [21:0] e,
                        input logic [21:0] m);
        sb_t s;
        s.rst = r; s.zero = z; s.exp = e; s.mask = m;
        sb.push_back(s);
    endtask

    task automatic test_reset();
        instr0 = 32'h00628233;  // add x4,x5,x6
        push(1, 0, 22'h0, c_ENABLE);
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd0, 0), c_FULL);
        push(0, 0, mk(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 4'd0, 0), c_FULL);
        push(0, 0, v_aluwb(), c_FULL);
        for (int i = 0; sb.size() > 0; i++) begin
            sb_t e;
            e = sb.pop_front();
            @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
            n_checks++;
            if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                n_errors++;
                $display("FAIL reset[%0d]: got %h want %h", i, w_obs0 & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_lw();
        instr0 = 32'h00452283;
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd0, 0), c_FULL);
        push(0, 0, mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 4'd0, 0), c_FULL);
        push(0, 0, mk(4'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0), c_FULL);
        push(0, 0, mk(4'd4, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 0), c_FULL);
        for (int i = 0; sb.size() > 0; i++) begin
            sb_t e;
            e = sb.pop_front();
            @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
            n_checks++;
            if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                n_errors++;
                $display("FAIL lw[%0d]: got %h want %h", i, w_obs0 & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_sw_reset();
        instr0 = 32'h00552223;  // sw x5,4(x10), aborted in MEMWRITE
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd1, 0), c_FULL);
        push(0, 0, mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd1, 4'd0, 0), c_FULL);
        push(1, 0, mk(4'd5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0), c_ENST);
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd1, 0), c_FULL);
        push(0, 0, mk(4'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd1, 4'd0, 0), c_FULL);
        push(0, 0, mk(4'd5, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0), c_FULL);
        for (int i = 0; sb.size() > 0; i++) begin
            sb_t e;
            e = sb.pop_front();
            @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
            n_checks++;
            if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                n_errors++;
                $display("FAIL sw_reset[%0d]: got %h want %h", i, w_obs0 & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_back_to_back_branch();
        logic [31:0] ins [3];
        logic        z   [3];
        logic        tk  [3];
        ins[0] = 32'h00401863; z[0] = 1'b0; tk[0] = 1'b1;  // bne, not equal
        ins[1] = 32'h00401863; z[1] = 1'b1; tk[1] = 1'b0;  // bne, equal
        ins[2] = 32'h00400863; z[2] = 1'b1; tk[2] = 1'b1;  // beq, equal
        for (int k = 0; k < 3; k++) begin
            instr0 = ins[k];
            push(0, z[k], v_fetch(), c_FULL);
            push(0, z[k], v_decode(2'd2, 0), c_FULL);
            push(0, z[k], mk(4'd9, tk[k], 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 4'd1, 0), c_FULL);
            for (int i = 0; sb.size() > 0; i++) begin
                sb_t e;
                e = sb.pop_front();
                @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
                n_checks++;
                if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                    n_errors++;
                    $display("FAIL branch%0d[%0d]: got %h want %h", k, i,
                             w_obs0 & e.mask, e.exp & e.mask);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] ins [3];
        logic [3:0]  st  [3];
        logic [1:0]  bs  [3];
        logic [3:0]  op  [3];
        ins[0] = 32'h40628233; st[0] = 4'd6; bs[0] = 2'd0; op[0] = 4'd1;  // sub
        ins[1] = 32'h4062d233; st[1] = 4'd6; bs[1] = 2'd0; op[1] = 4'd8;  // sra
        ins[2] = 32'h40028213; st[2] = 4'd7; bs[2] = 2'd1; op[2] = 4'd0;  // addi, f7 set
        for (int k = 0; k < 3; k++) begin
            instr0 = ins[k];
            push(0, 0, v_fetch(), c_FULL);
            push(0, 0, v_decode(2'd0, 0), c_FULL);
            push(0, 0, mk(st[k], 0, 0, 0, 0, 0, 2'd0, 2'd2, bs[k], 2'd0, op[k], 0), c_FULL);
            push(0, 0, v_aluwb(), c_FULL);
            for (int i = 0; sb.size() > 0; i++) begin
                sb_t e;
                e = sb.pop_front();
                @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
                n_checks++;
                if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                    n_errors++;
                    $display("FAIL alu%0d[%0d]: got %h want %h", k, i,
                             w_obs0 & e.mask, e.exp & e.mask);
                end
            end
        end
    endtask

    task automatic test_jal();
        instr0 = 32'h0100006f;
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd3, 0), c_FULL);
        push(0, 0, mk(4'd10, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 4'd0, 0), c_FULL);
        push(0, 0, v_aluwb(), c_FULL);
        for (int i = 0; sb.size() > 0; i++) begin
            sb_t e;
            e = sb.pop_front();
            @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
            n_checks++;
            if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                n_errors++;
                $display("FAIL jal[%0d]: got %h want %h", i, w_obs0 & e.mask, e.exp & e.mask);
            end
        end
    endtask

    task automatic test_illegal_nop();
        instr0 = 32'h0000007f;
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd0, 1), c_FULL);
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd0, 1), c_FULL);
        for (int i = 0; sb.size() > 0; i++) begin
            sb_t e;
            e = sb.pop_front();
            @(negedge clk); rst0 = e.rst; zero = e.zero; #1;
            n_checks++;
            if ((w_obs0 & e.mask) !== (e.exp & e.mask)) begin
                n_errors++;
                $display("FAIL illegal_nop[%0d]: got %h want %h", i, w_obs0 & e.mask, e.exp & e.mask);
            end
        end
        @(negedge clk); rst0 = 1'b1;
    endtask

    task automatic test_illegal_halt();
        instr1 = 32'h0000007f;
        push(0, 0, v_fetch(), c_FULL);
        push(0, 0, v_decode(2'd0, 1), c_FULL);
        for (int k = 0; k < 10; k++)
            push(0, 0, mk(4'd11, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0), c_FULL);
        push(1, 0, mk(4'd11, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 0), c_ENST);
        push(0, 0, v_fetch(), c_FULL);
        for (int i = 0; sb.size() > 0; i++) begin
            sb_t e;
            e = sb.pop_front();
            @(negedge clk); rst1 = e.rst; zero = e.zero; #1;
            n_checks++;
            if ((w_obs1 & e.mask) !== (e.exp & e.mask)) begin
                n_errors++;
                $display("FAIL illegal_halt[%0d]: got %h want %h", i, w_obs1 & e.mask, e.exp & e.mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_reset();
        test_back_to_back_branch();
        test_alu();
        test_jal();
        test_illegal_nop();
        test_illegal_halt();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Control FSM that sequences a multi-cycle RV32I datapath: shared instruction/data memory, instruction register, old-PC register, ALU-out register and memory-data register.
Each instruction is decoded into a fixed state sequence, and per-cycle mux selects, ALU op and write enables are driven.
Supports lw, sw, R-type ALU, I-type ALU, beq/bne and jal.
Sits between the instruction register/ALU zero flag and the datapath enables.

Parameters:
ILLEGAL_HALT, 0, 1: an unsupported opcode parks the FSM in HALT until reset; 0: it retires as a NOP.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
instr  in  32  instruction register contents, valid from DECODE onward
zero  in  1  ALU result == 0, combinational from datapath
pc_we  out  1  PC load enable
adr_src  out  1  memory address select: 0=PC, 1=result bus
mem_we  out  1  memory write enable
ir_we  out  1  instruction register and old-PC load enable
reg_we  out  1  register file write enable
res_src  out  2  result bus select: 0=ALU-out reg, 1=mem-data reg, 2=ALU direct
alu_src_a  out  2  0=PC, 1=old PC, 2=rs1
alu_src_b  out  2  0=rs2, 1=immediate, 2=constant 4
imm_src  out  2  0=I, 1=S, 2=B, 3=J
alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 SLTU
state  out  4  current state, for debug
illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Reset: synchronous; while rst=1, pc_we, mem_we, ir_we, reg_we and illegal are forced to 0. Next state is FETCH (0).
- rst asserted in any state, including mid-instruction and HALT, aborts the instruction; no partial writes occur in the rst cycle.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, HALT 11.
- Outputs are combinational from state and instr; BRANCH pc_we also depends on zero.
- Output defaults: every enable 0, every select 0, alu_ctrl ADD.
- FETCH: adr_src=0, ir_we=1, a=PC, b=4, ADD, res_src=2, pc_we=1. Next: DECODE.
- DECODE: a=old PC, b=imm, ADD (precomputes branch target into ALU-out). imm_src by opcode: lw/ALU-I I, sw S, branch B, jal J.
- DECODE transitions:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - otherwise illegal=1, then HALT if ILLEGAL_HALT else FETCH
- MEMADR: a=rs1, b=imm, ADD; imm_src=I for lw, S for sw. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, res_src=0. Next: MEMWB.
- MEMWB: res_src=1, reg_we=1. Next: FETCH.
- MEMWRITE: adr_src=1, res_src=0, mem_we=1. Next: FETCH.
- EXECR: a=rs1, b=rs2. alu_ctrl from funct3 and funct7[5]:
  - 000 ADD/SUB (SUB if f7[5])
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101 SRL/SRA (SRA if f7[5])
  - 110 OR, 111 AND
  - Next: ALUWB.
- EXECI: a=rs1, b=imm, imm_src=I. Same funct3 map, except funct3=000 is always ADD; funct7[5] is honoured only for 101. Next: ALUWB.
- ALUWB: res_src=0, reg_we=1. Next: FETCH.
- BRANCH: a=rs1, b=rs2, SUB, res_src=0.
  - pc_we = zero for funct3=000 (beq); pc_we = ~zero for funct3=001 (bne); 0 for any other funct3.
  - Next: FETCH.
- JAL: a=old PC, b=4, ADD, res_src=0, pc_we=1 (PC <- target held in ALU-out). Next: ALUWB (rd <- PC+4).
- HALT: all enables 0; remains in HALT until rst.
- Cycles per instruction:
  - lw 5; sw 4; R 4; I 4; branch 3; jal 4; illegal 2 (NOP mode).

Test Plan:
- Reset: rst=1 for one cycle from arbitrary state -> state=0, all enables 0 during rst. Next cycle: ir_we=1, pc_we=1, alu_src_b=2.
- lw (instr=32'h00452283) -> states 0,1,2,3,4,0. MEMADR drives imm_src=0, alu_src_a=2, alu_src_b=1. reg_we=1 only in MEMWB with res_src=1.
- bne taken/not: instr=32'h00401863 with zero=0 -> BRANCH pc_we=1. Same instr with zero=1 -> pc_we=0. beq 32'h00400863 with zero=1 -> pc_we=1. All in 3 cycles.
- R-type sub (32'h40628233) -> EXECR alu_ctrl=1. sra (32'h4062d233) -> 8. addi with funct7 bits set (32'h40028213) -> EXECI alu_ctrl=0.
- jal (32'h0100006f) -> states 0,1,10,8,0. JAL pc_we=1, alu_src_a=1. ALUWB reg_we=1.
- Illegal opcode 7'b1111111:
  - ILLEGAL_HALT=0: illegal pulses once, back to FETCH next cycle.
  - ILLEGAL_HALT=1: state=11 held 10 cycles with no enables; rst returns it to FETCH.
  - rst asserted in MEMWRITE suppresses mem_we that cycle.
